// File: rtl/div_seq_if.sv
// Bus between the EX-stage control unit and the sequential divider.
// Handshake: start is a request level sampled only while the divider is idle;
// the divider answers with stall_EX while it owns the operation and with a
// one-cycle done pulse carrying result. flush aborts an in-flight operation.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall_EX;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [1:0]       dbg_state;

    // Control-unit side.
    modport master (
        output start,
        output funct3,
        output a,
        output b,
        output flush,
        input  stall_EX,
        input  done,
        input  result,
        input  dbg_state
    );

    // Divider side.
    modport slave (
        input  start,
        input  funct3,
        input  a,
        input  b,
        input  flush,
        output stall_EX,
        output done,
        output result,
        output dbg_state
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring radix-2 division on operand magnitudes, one quotient bit per
// cycle, followed by a one-cycle sign fixup. Division by zero and the signed
// overflow case bypass the iteration and finish in one cycle.
module div_seq #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    div_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    count;
    logic             op_signed;    // DIV/REM
    logic             op_rem;       // REM/REMU select the remainder
    logic             neg_a;        // sign of the captured dividend
    logic             neg_b;        // sign of the captured divisor
    logic [WIDTH-1:0] dvs;          // divisor magnitude
    logic [WIDTH-1:0] rem;          // partial remainder
    logic [WIDTH-1:0] quo;          // dividend shifting out / quotient shifting in
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_prev;  // value to restore if DONE is flushed

    // funct3[2] is always 1 for this instruction group; only [1:0] select the op.
    logic unused_f3;
    assign unused_f3 = bus.funct3[2];

    // Operand decode used when a request is accepted in IDLE.
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             ovf;
    logic             accept;
    logic [WIDTH-1:0] fast_quo;
    logic [WIDTH-1:0] fast_rem;

    // Decode the incoming request and the special cases that skip iteration.
    always_comb begin
        in_signed = ~bus.funct3[0];
        a_neg     = in_signed & bus.a[WIDTH-1];
        b_neg     = in_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        b_zero    = (bus.b == '0);
        ovf       = in_signed && (bus.a == MIN_NEG) && (bus.b == '1);
        accept    = (state == IDLE) && bus.start && !bus.flush;
        fast_quo  = b_zero ? '1 : bus.a;
        fast_rem  = b_zero ? bus.a : '0;
    end

    // One restoring step: shift {rem,quo} left and try to subtract the divisor.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             fits;
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs};
        fits   = ~diff[WIDTH+1];
    end

    // Sign fixup applied to the magnitude results after the last step.
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    always_comb begin
        quo_fix = (op_signed && (neg_a ^ neg_b)) ? -quo : quo;
        rem_fix = (op_signed && neg_a) ? -rem : rem;
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            op_signed   <= 1'b0;
            op_rem      <= 1'b0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_prev <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_signed <= in_signed;
                        op_rem    <= bus.funct3[1];
                        neg_a     <= a_neg;
                        neg_b     <= b_neg;
                        dvs       <= b_mag;
                        count     <= CNT_LOAD;
                        if (b_zero || ovf) begin
                            quo         <= fast_quo;
                            rem         <= fast_rem;
                            result_prev <= result_q;
                            result_q    <= bus.funct3[1] ? fast_rem : fast_quo;
                            done_q      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        if (fits) begin
                            rem <= diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        if (count == '0) begin
                            state <= FIX;
                        end else begin
                            count <= count - CNT_ONE;
                        end
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        quo         <= quo_fix;
                        rem         <= rem_fix;
                        result_prev <= result_q;
                        result_q    <= op_rem ? rem_fix : quo_fix;
                        done_q      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                    // A flushed DONE must leave the previous result visible.
                    if (bus.flush) begin
                        result_q <= result_prev;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall covers the accept cycle and the iteration; it drops in DONE so the
    // instruction retires alongside the done pulse.
    assign bus.stall_EX  = accept || (state == CALC) || (state == FIX);
    assign bus.done      = done_q & ~bus.flush;
    assign bus.result    = (done_q && bus.flush) ? result_prev : result_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases, special operands, flush,
// asynchronous reset, and randomized back-to-back operations.
module tb_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] exp_hold = '0;
  int           busy_start = 0;
  int           stall_end = -1;
  int           done_at = -10;
  int           op_c0 = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: RV32M division semantics with plain arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (y == 0) begin
      q = '1;
      r = x;
    end else if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = x;
      r = '0;
    end else if (!f3[0]) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    if (y == 0) return 1;
    if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return W + 2;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           ec;
    if (rst_n) begin
      check("stall_EX", {31'd0, bus.stall_EX}, {31'd0, (cyc >= busy_start) && (cyc <= stall_end)});
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 result %h expected no done (cycle %0d)",
                   bus.result, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", bus.result, e);
          check("done_cycle", cyc, ec);
          exp_hold = e;
        end
      end else begin
        check("result_hold", bus.result, exp_hold);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle and record what must come back.
  task automatic issue(input logic [2:0] f3, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    lat = latency(f3, x, y);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = x;
    bus.b      = y;
    op_c0      = cyc;
    busy_start = cyc;
    stall_end  = cyc + lat - 1;
    done_at    = cyc + lat;
    exp_q.push_back(model(f3, x, y));
    exp_cyc_q.push_back(cyc + lat);
    tick();
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
  endtask

  task automatic wait_idle();
    while (cyc < done_at + 1) tick();
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(f3, x, y);
    wait_idle();
  endtask

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]   f3;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           kind;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = DIVU;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {30'd0, bus.dbg_state}, '0);
    check("reset_done", {31'd0, bus.done}, '0);
    check("reset_result", bus.result, '0);
    check("reset_stall", {31'd0, bus.stall_EX}, '0);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic cases
    run_op(DIVU, 32'd100, 32'd7);
    run_op(REMU, 32'd100, 32'd7);
    run_op(DIV, -32'sd20, 32'd3);
    run_op(REM, -32'sd20, 32'd3);
    run_op(REM, 32'd20, -32'sd3);
    run_op(DIVU, 32'h1234, 32'd0);
    run_op(DIV, 32'h1234, 32'd0);
    run_op(REM, 32'h1234, 32'd0);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in cycle 10 of an operation, then a clean follow-up op
    issue(DIVU, 32'd100, 32'd7);
    while (cyc < op_c0 + 10) tick();
    bus.flush = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    stall_end = cyc;
    done_at   = cyc;
    tick();
    bus.flush = 1'b0;
    check("flush_to_idle", {30'd0, bus.dbg_state}, '0);
    run_op(DIVU, 32'd9, 32'd2);

    // Start pulses mid-operation must not recapture operands
    issue(DIV, -32'sd1000, 32'd7);
    while (cyc < op_c0 + 5) tick();
    bus.start = 1'b1; bus.funct3 = DIVU; bus.a = 32'd5; bus.b = 32'd1;
    tick();
    bus.start = 1'b0;
    while (cyc < op_c0 + 20) tick();
    bus.start = 1'b1; bus.funct3 = REMU; bus.a = 32'd77; bus.b = 32'd0;
    tick();
    bus.start = 1'b0;
    wait_idle();

    // Flush together with start in IDLE: request is dropped
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = DIVU; bus.a = 32'd50; bus.b = 32'd5;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_blocks_start", {30'd0, bus.dbg_state}, '0);
    tick();

    // Flush in the DONE cycle: no pulse, previous result kept
    issue(REMU, 32'd1000, 32'd33);
    while (cyc < done_at) tick();
    bus.flush = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    tick();
    bus.flush = 1'b0;
    run_op(DIVU, 32'd1000, 32'd33);

    // Asynchronous reset in cycle 15 of an operation
    issue(DIVU, 32'd123456, 32'd789);
    while (cyc < op_c0 + 15) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_state", {30'd0, bus.dbg_state}, '0);
    check("async_reset_done", {31'd0, bus.done}, '0);
    check("async_reset_result", bus.result, '0);
    check("async_reset_stall", {31'd0, bus.stall_EX}, '0);
    exp_q.delete();
    exp_cyc_q.delete();
    exp_hold  = '0;
    stall_end = -1;
    done_at   = cyc;
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized operations, sometimes re-presenting start during DONE
    for (int i = 0; i < 40; i++) begin
      f3   = {1'b1, 2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 6);
      case (kind)
        0: begin x = $urandom; y = '0; end
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 1000); y = $urandom_range(1, 50); end
        3: begin x = $urandom; y = $urandom; end
        4: begin x = $urandom; y = $urandom_range(1, 255); end
        5: begin x = $urandom; y = -$urandom_range(1, 100); end
        default: begin x = -$urandom_range(0, 5000); y = $urandom_range(1, 20); end
      endcase
      while (cyc < done_at) tick();
      if (cyc == done_at && $urandom_range(0, 2) == 0) begin
        bus.start = 1'b1; bus.funct3 = f3; bus.a = x; bus.b = y;
        tick();
      end else begin
        tick();
        repeat ($urandom_range(0, 3)) tick();
      end
      issue(f3, x, y);
    end
    wait_idle();

    // Drain: every expected response must have arrived
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check("pending_responses", exp_q.size(), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
